// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the ysyx_22050612 core: datapath widths, reset pc
// and the fetch entry layout carried from IFU to IDU.
package ysyx_22050612_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ysyx_22050612_ifq_mem.sv
// Instruction fetch queue storage: DEPTH fetch entries, one synchronous write
// port and one asynchronous read port. Entries carry no reset; validity is
// tracked entirely by the pointers and count in the queue controller.
module ysyx_22050612_ifq_mem
    import ysyx_22050612_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         wr_en,
    input  logic [AW-1:0] wr_addr,
    input  fetch_entry_t wr_data,
    input  logic [AW-1:0] rd_addr,
    output fetch_entry_t rd_data
);

    fetch_entry_t mem_q [DEPTH];

    // Write the offered entry into the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/ysyx_22050612_ifq.sv
// Instruction fetch queue between IFU and IDU. Holds up to DEPTH fetched
// {pc, inst} pairs in FIFO order, with single-cycle first-word latency and a
// flush input that discards everything on a redirect.
// Optional macro YSYX_22050612_IFQ_PERF_EN adds perf_full_cyc and
// perf_flush_cnt performance counters.
module ysyx_22050612_ifq
    import ysyx_22050612_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [ILEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [ILEN-1:0]          out_inst,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
`ifdef YSYX_22050612_IFQ_PERF_EN
    ,
    output logic [63:0]              perf_full_cyc,
    output logic [31:0]              perf_flush_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [AW-1:0] head_q;
    logic [AW-1:0] tail_q;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;
    logic          not_empty;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;

    // in_ready is held low while reset is asserted so the IFU never sees an
    // accept from a queue that is being cleared.
    assign not_empty = (count_q != '0);
    assign in_ready  = rst && (count_q < FULL_COUNT);
    assign out_valid = not_empty && !flush;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready;

    assign wr_entry.pc   = in_pc;
    assign wr_entry.inst = in_inst;

    ysyx_22050612_ifq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (tail_q),
        .wr_data (wr_entry),
        .rd_addr (head_q),
        .rd_data (head_entry)
    );

    // Pointer and occupancy update; flush wins over any push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + AW'(1);
            end
            if (pop) begin
                head_q <= head_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign out_pc   = not_empty ? head_entry.pc   : '0;
    assign out_inst = not_empty ? head_entry.inst : '0;
    assign count    = count_q;

`ifdef YSYX_22050612_IFQ_PERF_EN
    // Count IFU stall cycles caused by a full queue and flush cycles; both wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_full_cyc  <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (in_valid && !in_ready) begin
                perf_full_cyc <= perf_full_cyc + 64'd1;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22050612_ifq.sv
// Self-checking bench for ysyx_22050612_ifq. A queue-of-entries reference
// model predicts occupancy, head entry and handshakes each cycle; directed
// scenarios are followed by a randomized run.
// Honours YSYX_22050612_IFQ_PERF_EN for the optional counter ports.
module tb_ysyx_22050612_ifq;
    import ysyx_22050612_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;
    logic        flush;
    logic [2:0]  count;
`ifdef YSYX_22050612_IFQ_PERF_EN
    logic [63:0] perf_full_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_entry_t     model_q[$];
    longint unsigned  exp_full_cyc  = 0;
    int unsigned      exp_flush_cnt = 0;
    logic [63:0]      next_pc;

    ysyx_22050612_ifq #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .flush     (flush),
        .count     (count)
`ifdef YSYX_22050612_IFQ_PERF_EN
        ,
        .perf_full_cyc  (perf_full_cyc),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        fetch_entry_t head;
        logic         exp_valid;
        logic         exp_ready;
        head      = '0;
        if (model_q.size() != 0) head = model_q[0];
        exp_valid = (model_q.size() != 0) && !flush;
        exp_ready = rst && (model_q.size() < DEPTH);
        compare({tag, ".out_valid"}, 64'(out_valid), 64'(exp_valid));
        compare({tag, ".in_ready"},  64'(in_ready),  64'(exp_ready));
        compare({tag, ".count"},     64'(count),     64'(model_q.size()));
        compare({tag, ".out_pc"},    out_pc,         head.pc);
        compare({tag, ".out_inst"},  64'(out_inst),  64'(head.inst));
`ifdef YSYX_22050612_IFQ_PERF_EN
        compare({tag, ".perf_full_cyc"},  perf_full_cyc,        exp_full_cyc);
        compare({tag, ".perf_flush_cnt"}, 64'(perf_flush_cnt),  64'(exp_flush_cnt));
`endif
    endtask

    // Drive one cycle of inputs, check outputs, then advance model and clock.
    task automatic applyStimulus(input logic iv, input logic [63:0] pc, input logic [31:0] inst,
                                 input logic ordy, input logic fl, input string tag);
        logic         has_room;
        logic         accept;
        logic         take;
        fetch_entry_t e;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        checkOutput(tag);
        has_room = model_q.size() < DEPTH;
        accept   = iv && rst && has_room && !fl;
        take     = (model_q.size() != 0) && !fl && ordy;
        if (!rst) begin
            model_q.delete();
            exp_full_cyc  = 0;
            exp_flush_cnt = 0;
        end else begin
            if (iv && !has_room) exp_full_cyc++;
            if (fl) exp_flush_cnt++;
            if (fl) begin
                model_q.delete();
            end else begin
                if (take) void'(model_q.pop_front());
                if (accept) begin
                    e.pc   = pc;
                    e.inst = inst;
                    model_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds everything at zero even with an offer present.
        applyStimulus(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0, "in_reset");
        applyStimulus(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0, "in_reset");

        // First word after release appears exactly one cycle later.
        rst = 1'b1;
        applyStimulus(1'b1, 64'h8000_0000, 32'h0000_0413, 1'b0, 1'b0, "first_push");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, "first_word");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "first_pop");

        // Fill to DEPTH, then a refused fifth offer and further blocked cycles.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 64'h8000_0000 + 64'(4 * i), $urandom, 1'b0, 1'b0, "fill");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 64'h8000_0010, 32'h1234_5678, 1'b0, 1'b0, "full_blocked");
        applyStimulus(1'b1, 64'h8000_0010, 32'h1234_5678, 1'b1, 1'b0, "full_pop");
        for (int i = 0; i < DEPTH + 1; i++)
            applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "drain");

        // Continuous streaming with pointer wrap.
        next_pc = 64'h8000_0000;
        for (int i = 0; i < 21; i++) begin
            applyStimulus(1'b1, next_pc, $urandom, 1'b1, 1'b0, "stream");
            next_pc += 64'd4;
        end
        for (int i = 0; i < 2; i++)
            applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "stream_drain");

        // Flush with three entries and a concurrent offer, then on empty queue.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 64'h8000_0100 + 64'(4 * i), $urandom, 1'b0, 1'b0, "pre_flush");
        applyStimulus(1'b1, 64'hDEAD_0000, 32'hDEAD_BEEF, 1'b1, 1'b1, "flush");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, "post_flush");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, "flush_empty");
        applyStimulus(1'b1, 64'h8000_0200, 32'h0000_0013, 1'b0, 1'b0, "after_flush");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "after_flush");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, "after_flush");

        // Reset mid-stream clears outputs without waiting for a clock edge.
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 64'h8000_0300 + 64'(4 * i), $urandom, 1'b0, 1'b0, "pre_reset");
        rst = 1'b0;
        model_q.delete();
        exp_full_cyc  = 0;
        exp_flush_cnt = 0;
        #1;
        checkOutput("async_reset");
        applyStimulus(1'b1, 64'h8000_0400, 32'h0, 1'b0, 1'b0, "held_reset");
        rst = 1'b1;

        // Perf scenario: full queue blocked five cycles, then two flushes.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(1'b1, 64'h8000_0000 + 64'(4 * i), $urandom, 1'b0, 1'b0, "perf_fill");
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 64'h8000_0010, 32'h0, 1'b0, 1'b0, "perf_block");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, "perf_flush");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b1, "perf_flush");
        applyStimulus(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, "perf_done");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, "random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050612_ifq.md
YSYX_22050612_IFQ -- requirements
Module: ysyx_22050612_ifq

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  IFU offers a fetched instruction.
REQ-005 SHALL have port in_ready  output  1  queue accepts the offer this cycle.
REQ-006 SHALL have port in_pc  input  64  pc of offered instruction.
REQ-007 SHALL have port in_inst  input  32  offered instruction word, already lane-selected by pc[2].
REQ-008 SHALL have port out_valid  output  1  head entry available to IDU.
REQ-009 SHALL have port out_ready  input  1  IDU consumes head this cycle.
REQ-010 SHALL have port out_pc  output  64  pc of head entry.
REQ-011 SHALL have port out_inst  output  32  instruction of head entry.
REQ-012 SHALL have port flush  input  1  redirect (branch/jump/trap); discard all contents.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-014 Push SHALL occur at a rising edge when in_valid && in_ready && !flush; the {in_pc, in_inst} pair is written at the tail.
REQ-015 Pop SHALL occur at a rising edge when out_valid && out_ready; the head advances by one.
REQ-016 in_ready SHALL equal (count < DEPTH) with no combinational dependence on out_ready; a full queue refuses a push even while popping.
REQ-017 out_valid SHALL equal (count != 0) && !flush.
REQ-018 out_pc/out_inst SHALL present the head entry from registered storage; when count == 0 they SHALL be all-zero.
REQ-019 First-word latency SHALL be one cycle: a push at edge N makes out_valid high after edge N; there is no same-cycle bypass.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-021 Head/tail pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow below 0.
REQ-022 Flush SHALL take priority over push and pop: at the edge count, head and tail go to 0, and the push offered in the flush cycle is dropped.
REQ-023 Entry storage SHALL NOT require reset; only pointers, count and counters are reset.

Reset
REQ-024 While rst == 0, asynchronously: count = 0, pointers = 0, out_valid = 0, in_ready = 0, out_pc = 0, out_inst = 0.
REQ-025 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-026 Reset asserted mid-operation SHALL discard all entries, exactly as a flush does.

Configuration
REQ-027 With macro YSYX_22050612_IFQ_PERF_EN defined, the block SHALL add output perf_full_cyc (64 bits) and output perf_flush_cnt (32 bits).
REQ-028 perf_full_cyc SHALL count cycles with in_valid && !in_ready; perf_flush_cnt SHALL count cycles with flush == 1; both SHALL wrap silently and reset to 0.
REQ-029 Without the macro, these ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-030 Package ysyx_22050612_pkg SHALL hold XLEN = 64, ILEN = 32, RESET_PC = 64'h80000000, and the typedef fetch_entry_t {pc[XLEN], inst[ILEN]}.
REQ-031 Storage SHALL be one sub-module, ysyx_22050612_ifq_mem: DEPTH x fetch_entry_t, one write port, one asynchronous read port.
REQ-032 Pointer, count and flush logic SHALL stay in ysyx_22050612_ifq.

Verification
REQ-033 Reset scenario: after release, push pc = 80000000 / inst = 00000413 -> out_valid rises one cycle later with the same pc/inst; count = 1.
REQ-034 Fill scenario: push 4 entries, pc 80000000..8000000c, out_ready = 0 -> in_ready = 0, count = 4; a fifth offer is not accepted.
REQ-035 Streaming scenario: continuous push and pop for 20 cycles -> output pc sequence 80000000 + 4k is in order, with no gaps after the first word.
REQ-036 Flush scenario: with 3 entries, assert flush together with in_valid -> the next cycle has count = 0 and out_valid = 0; the flushed-cycle push is never output.
REQ-037 Wrap/reset scenario: after 10 push/pop pairs, the pointers have wrapped and ordering is intact; asserting rst mid-stream forces the outputs to 0 immediately, without waiting for a clock edge.
REQ-038 Perf scenario (YSYX_22050612_IFQ_PERF_EN): 5 blocked cycles while full plus 2 flushes -> perf_full_cyc = 5 and perf_flush_cnt = 2.
